// File: rtl/dm_arbiter.sv
// Data-memory port arbiter between the core and a burst loader. The core has
// priority, and a starvation counter forces a loader grant after STARVE_MAX denials.
module dm_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_stall,
    input  logic          ld_start,
    input  logic [AW-1:0] ld_base,
    input  logic [7:0]    ld_len,
    input  logic          ld_dir_we,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_ready,
    output logic [DW-1:0] ld_rdata,
    output logic          ld_busy,
    output logic          ld_done,
    output logic [AW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    output logic          dm_we,
    input  logic [DW-1:0] dm_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BURST = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
    localparam logic [3:0] STV_MAX = 4'(STARVE_MAX);

    logic [1:0]    state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic          dir_q, dir_d;
    logic [3:0]    stv_q, stv_d;
    logic          ld_gnt;

    assign ld_gnt = (state_q == S_BURST) && ld_valid && (!core_req || stv_q == STV_MAX);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        dir_d   = dir_q;
        stv_d   = stv_q;
        case (state_q)
            S_IDLE: begin
                stv_d = '0;
                if (ld_start) begin
                    if (ld_len != 8'd0) begin
                        ptr_d   = ld_base;
                        cnt_d   = ld_len;
                        dir_d   = ld_dir_we;
                        state_d = S_BURST;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_BURST: begin
                if (ld_gnt) begin
                    ptr_d = ptr_q + {{(AW-1){1'b0}}, 1'b1};
                    cnt_d = cnt_q - 8'd1;
                    stv_d = '0;
                    if (cnt_q == 8'd1) state_d = S_DONE;
                end else if (!ld_valid) begin
                    stv_d = '0;
                end else if (core_req && stv_q != STV_MAX) begin
                    stv_d = stv_q + 4'd1;
                end
            end
            S_DONE: begin
                stv_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            dir_q   <= 1'b0;
            stv_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            dir_q   <= dir_d;
            stv_q   <= stv_d;
        end
    end

    // The core path is muxed through whenever the loader holds no grant; the core
    // re-presents a stalled access itself, so nothing about it is stored here.
    assign ld_ready   = ld_gnt;
    assign core_stall = ld_gnt & core_req;
    assign dm_addr    = ld_gnt ? ptr_q    : core_addr;
    assign dm_wdata   = ld_gnt ? ld_wdata : core_wdata;
    assign dm_we      = !RST && (ld_gnt ? dir_q : (core_we & core_req));
    assign ld_rdata   = dm_rdata;
    assign ld_busy    = (state_q == S_BURST);
    assign ld_done    = (state_q == S_DONE);

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
Shares the single data-memory port between the processor core and an external burst loader (test/debug image loader or DMA).
- Sits between the core's memory-address/write-data/DM_WE path and the data memory.
- Drives a stall to the core controller so that PC_WRITE and RF_WE are held while the loader owns the port.
- Core has priority. A starvation counter guarantees the loader forward progress.

Parameters:
AW, 16, address width (data-memory address)
DW, 32, data width
STARVE_MAX, 4, consecutive denied loader-valid cycles before the loader is forced a grant (legal 1..15)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous, active-high reset
core_req  input  1  core wants the memory port this cycle (load or store instruction in memory phase)
core_we  input  1  core store
core_addr  input  AW  core address
core_wdata  input  DW  core store data
core_stall  output  1  core must hold state this cycle; its access did not occur
ld_start  input  1  pulse: begin burst
ld_base  input  AW  burst start address, sampled on accepted ld_start
ld_len  input  8  burst beat count, sampled on accepted ld_start
ld_dir_we  input  1  1 = write burst, 0 = read burst, sampled on accepted ld_start
ld_valid  input  1  loader offers a beat (write data valid / ready to take read data)
ld_wdata  input  DW  loader write data
ld_ready  output  1  beat accepted this cycle
ld_rdata  output  DW  read data, valid when ld_ready=1 on a read burst
ld_busy  output  1  burst in progress
ld_done  output  1  one-cycle pulse after the final beat
dm_addr  output  AW  to data memory
dm_wdata  output  DW  to data memory
dm_we  output  1  to data memory
dm_rdata  input  DW  from data memory, combinational read

Behaviour:
- FSM states: IDLE, BURST, DONE. Reset enters IDLE.
- Registers: beat counter cnt[7:0], address pointer ptr[AW-1:0], direction flag, starvation counter stv[3:0].
- Reset values: state=IDLE, cnt=0, ptr=0, stv=0, ld_busy=0, ld_done=0.
- Effect of reset on combinational outputs: ld_ready=0, dm_we=0 (no grant exists in IDLE); core_stall=0.
- IDLE:
  - ld_start=1 with ld_len!=0: latch ld_base into ptr, ld_len into cnt, ld_dir_we into direction; go to BURST.
  - ld_start=1 with ld_len=0: go to DONE; no memory access.
  - Other inputs: stay in IDLE.
- BURST, grant decision (combinational, same cycle):
  - Loader is granted when ld_valid=1 AND (core_req=0 OR stv==STARVE_MAX). Otherwise the core is granted.
- Loader grant:
  - ld_ready=1; dm_addr=ptr; dm_we=direction; dm_wdata=ld_wdata; ld_rdata=dm_rdata.
  - core_stall=core_req.
  - On the clock edge: ptr<=ptr+1, wrapping from all-ones to 0; cnt<=cnt-1; stv<=0.
  - If cnt==1: go to DONE.
- Core grant, or no loader beat:
  - dm_addr=core_addr, dm_wdata=core_wdata, dm_we=core_we&core_req, ld_ready=0, core_stall=0.
  - stv increments (saturating at STARVE_MAX) when ld_valid=1 and core_req=1.
  - stv clears when ld_valid=0.
- DONE:
  - ld_done=1 for exactly one cycle, ld_busy=0, core has the port; then go to IDLE.
  - ld_start in DONE is ignored.
- ld_busy=1 only in BURST. ld_start while busy is ignored (no relatch).
- IDLE/DONE port ownership: core owns the port, core_stall=0, ld_ready=0.
- Latency:
  - Write beat commits at the edge ending the granted cycle.
  - Read beat data is same-cycle combinational.
  - First beat is possible the cycle after the ld_start accept.
- A held core_req with repeated stalls re-presents the same access. The arbiter keeps no core state.
- RST asserted mid-burst: burst abandoned immediately, no ld_done, dm_we drops to 0 asynchronously.

Test Plan:
- Write burst, no core traffic:
  - Stimulus: ld_base=0x0010, ld_len=3, ld_dir_we=1, ld_valid held high, wdata A,B,C.
  - Response: mem[0x10..0x12]=A,B,C; ld_ready high 3 cycles; ld_done pulses in cycle 5 after start; ld_busy low after.
- Starvation, STARVE_MAX=4:
  - Stimulus: core_req and ld_valid held high during a read burst.
  - Response: core granted 4 cycles, loader granted on the 5th with core_stall=1; pattern repeats until cnt exhausts.
- Wrap-around:
  - Stimulus: ld_base=0xFFFE, ld_len=4, write burst.
  - Response: writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Zero length:
  - Stimulus: ld_len=0 with ld_start.
  - Response: ld_done next cycle, ld_busy never high, dm_we never driven by loader.
- Start while busy:
  - Stimulus: second ld_start with ld_base=0x0100 mid-burst.
  - Response: ignored; original addresses continue; single ld_done.
- Reset mid-burst:
  - Stimulus: RST pulse after beat 1 of ld_len=5.
  - Response: dm_we=0 during reset, state IDLE, ld_busy=0, no ld_done; a fresh burst then runs normally.
